seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode, multi-digit 7-segment display. All digits share one combinational hex-to-segment decoder.
Each cycle, the block selects which digit's nibble feeds the decoder and which anode is enabled, with an anti-ghosting blank window between digits. It also provides leading-zero blanking and a tear-free double-buffered load handshake. It sits between the value producer (counter/ALU/register file) and the decoder plus the board anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
CLK_DIV, 50000, clock cycles per digit slot (blank + show)
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; requires 1 <= BLANK_CYCLES < CLK_DIV (elaboration-time check)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
value_in  input  4*NUM_DIGITS  hex digits; digit 0 (least significant) = value_in[3:0]
dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
load_valid  input  1  producer offers value_in/dp_in
load_ready  output  1  pending buffer free; transfer occurs when load_valid & load_ready
lz_blank_en  input  1  enable leading-zero blanking (sampled live)
nibble_out  output  4  hex digit for the shared decoder, = shadow digit[idx]
digit_en_n  output  NUM_DIGITS  anode enables, active-low, at most one bit low
dp_out_n  output  1  decimal point segment, active-low
frame_done  output  1  one-cycle pulse at the end of the last digit's slot

Behaviour:
- Reset:
  - Slot counter cnt = 0 and digit index idx = 0.
  - shadow and pending value/dp registers cleared to 0; pending_full = 0.
  - Outputs: digit_en_n = all 1s, dp_out_n = 1, nibble_out = 0, frame_done = 0, load_ready = 1.
  - The first cycle after rst deasserts is cnt = 0.
- Slot timing:
  - cnt counts 0..CLK_DIV-1, then wraps to 0.
  - On wrap, idx advances: idx = NUM_DIGITS-1 goes to 0, otherwise idx+1.
- Phases within a slot:
  - BLANK (cnt < BLANK_CYCLES): digit_en_n = all 1s and dp_out_n = 1.
  - SHOW (cnt >= BLANK_CYCLES): digit_en_n[idx] = 0 and all other bits = 1; dp_out_n = ~dp_shadow[idx].
  - Exception: if the digit is leading-zero suppressed, digit_en_n stays all 1s and dp_out_n stays 1 for the whole slot.
- nibble_out = shadow digit[idx] throughout the slot, including BLANK, so the decoder settles before the anode turns on.
- All outputs are registered. The output values for the cnt = k cycle appear in that same cycle, as seen by a bench sampling after the clock edge.
- Leading-zero suppression:
  - Digit idx is suppressed when lz_blank_en = 1, idx != 0, and shadow digits idx..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - dp_in does not affect suppression.
- frame_done = 1 exactly in the cycle where idx = NUM_DIGITS-1 and cnt = CLK_DIV-1 (the frame boundary).
- Load handshake (double buffer):
  - load_ready = ~pending_full.
  - When load_valid & load_ready: pending <= {value_in, dp_in} and pending_full <= 1.
  - When load_valid is high while load_ready = 0: the load is ignored; the producer must hold its data.
- Commit:
  - In the frame_done cycle, if pending_full was 1 at the start of that cycle, then shadow <= pending and pending_full <= 0. load_ready returns to 1 the next cycle.
  - The display therefore changes only at frame start, so there is no tearing.
- Load in the frame_done cycle: if pending_full = 0 and a load is accepted in that same cycle, the data is captured into pending only. It commits at the next frame boundary, not the current one.
- Reset mid-operation: any cycle with rst = 1 forces the full reset state on the next edge. Anodes go off immediately, and pending data is discarded.
- No arithmetic beyond the counters. cnt width = clog2(CLK_DIV) and idx width = clog2(NUM_DIGITS), each at least 1.

Test Plan:
(All tests use NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.)
1. Reset: hold rst for 3 cycles, then release → digit_en_n=1111, dp_out_n=1, load_ready=1, nibble_out=0. First slot is 2 cycles of 1111, then 6 cycles of 1110. frame_done first pulses at cycle 31 after release.
2. Scan order: load 0x1234 with dp_in=0010 and wait for commit → in the following frame nibble_out goes 4,3,2,1. digit_en_n goes 1110,1101,1011,0111 (each 6 cycles, preceded by 2 blank cycles of 1111). dp_out_n=0 only in digit 1's SHOW. frame_done repeats every 32 cycles.
3. Tear-free load: load 0xABCD at cnt=3 of digit 1 → load_ready=0 next cycle. Display keeps its old value until frame_done; shadow=0xABCD from the next frame; load_ready=1 the cycle after frame_done. A second load_valid with 0x5555 while ready=0 is dropped.
4. Leading zeros: with lz_blank_en=1, load 0x0050 → digits 3 and 2 stay 1111 through their slots, digit 1 shows 5, digit 0 shows 0. Load 0x0000 → only digit 0 is enabled. With lz_blank_en=0 → all four digits are enabled.
5. Boundary load: with pending empty, assert load_valid with 0x9999 exactly in the frame_done cycle → accepted; the display shows the old value for one more frame, then 0x9999.
6. Reset mid-SHOW: assert rst during digit 2 SHOW with pending_full=1 → next cycle digit_en_n=1111, idx=0, shadow=0, load_ready=1. After release, the scan restarts at digit 0, cnt=0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Drives one shared decoder nibble, the anodes and the decimal point, and double-buffers loads.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    lz_blank_en,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    dp_out_n,
    output logic                    frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seven_seg_scan_ctrl: NUM_DIGITS must be 2..8");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
        $error("seven_seg_scan_ctrl: need 1 <= BLANK_CYCLES < CLK_DIV");
    end

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_full;

    logic                    slot_end;
    logic                    frame_end;
    logic                    commit;
    logic                    accept;
    logic [CW-1:0]           cnt_nxt;
    logic [IW-1:0]           idx_nxt;
    logic [4*NUM_DIGITS-1:0] shadow_val_nxt;
    logic [NUM_DIGITS-1:0]   shadow_dp_nxt;

    logic [3:0]              nib_nxt;
    logic                    dp_bit;
    logic                    upper_zero;
    logic                    suppress;
    logic                    show;
    logic [NUM_DIGITS-1:0]   en_nxt;
    logic                    dp_nxt;
    logic                    fd_nxt;

    assign load_ready = ~pend_full;

    // Slot/digit position of the next cycle and the buffer transfer decisions.
    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        cnt_nxt   = slot_end ? '0 : cnt + CW'(1);
        idx_nxt   = idx;
        if (slot_end) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
        commit         = frame_end && pend_full;
        accept         = load_valid && !pend_full;
        shadow_val_nxt = commit ? pend_val : shadow_val;
        shadow_dp_nxt  = commit ? pend_dp : shadow_dp;
    end

    // Output values for the next cycle, so registered outputs line up with cnt.
    always_comb begin
        nib_nxt    = '0;
        dp_bit     = 1'b0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                nib_nxt = shadow_val_nxt[4*i +: 4];
                dp_bit  = shadow_dp_nxt[i];
            end
            if (IW'(i) >= idx_nxt && shadow_val_nxt[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        suppress = lz_blank_en && (idx_nxt != '0) && upper_zero;
        show     = (cnt_nxt >= CNT_SHOW) && !suppress;
        en_nxt   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (show && idx_nxt == IW'(i)) begin
                en_nxt[i] = 1'b0;
            end
        end
        dp_nxt = show ? ~dp_bit : 1'b1;
        fd_nxt = (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);
    end

    // Counters, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_full  <= 1'b0;
            nibble_out <= '0;
            digit_en_n <= '1;
            dp_out_n   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shadow_val <= shadow_val_nxt;
            shadow_dp  <= shadow_dp_nxt;
            if (commit) begin
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_val  <= value_in;
                pend_dp   <= dp_in;
                pend_full <= 1'b1;
            end
            nibble_out <= nib_nxt;
            digit_en_n <= en_nxt;
            dp_out_n   <= dp_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = ND * DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*ND-1:0] value_in;
    logic [ND-1:0] dp_in;
    logic          load_valid;
    logic          load_ready;
    logic          lz_blank_en;
    logic [3:0]    nibble_out;
    logic [ND-1:0] digit_en_n;
    logic          dp_out_n;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .CLK_DIV     (DIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .lz_blank_en(lz_blank_en),
        .nibble_out (nibble_out),
        .digit_en_n (digit_en_n),
        .dp_out_n   (dp_out_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame plus the two buffers.
    int pos;
    int shadow_v, shadow_dp, pend_v, pend_dp;
    bit pfull, lz_s, mvalid = 1'b0;

    // Advance the model on every edge and compare all outputs just after it.
    always @(posedge clk) begin
        int d, k, upper, en, dpx;
        bit sup, shw;
        #1;
        if (rst) begin
            pos = 0; shadow_v = 0; shadow_dp = 0;
            pend_v = 0; pend_dp = 0; pfull = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (pos == FRAME - 1 && pfull) begin
                shadow_v = pend_v; shadow_dp = pend_dp; pfull = 0;
            end else if (load_valid && !pfull) begin
                pend_v = int'(value_in); pend_dp = int'(dp_in); pfull = 1;
            end
            pos = (pos + 1) % FRAME;
        end
        lz_s = lz_blank_en;
        if (mvalid) begin
            d     = pos / DIV;
            k     = pos % DIV;
            upper = shadow_v >> (4 * d);
            sup   = lz_s && d != 0 && upper == 0;
            shw   = k >= BLK && !sup;
            en    = shw ? (~(1 << d)) & 'hF : 'hF;
            dpx   = shw ? ((shadow_dp >> d) & 1) ^ 1 : 1;
            check("m_nibble", int'(nibble_out), upper & 'hF);
            check("m_en", int'(digit_en_n), en);
            check("m_dp", int'(dp_out_n), dpx);
            check("m_fd", int'(frame_done), int'(pos == FRAME - 1));
            check("m_ready", int'(load_ready), int'(!pfull));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stop at the negedge of the next frame_done cycle, bounded.
    task automatic wait_frame();
        int t;
        t = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && t < 2 * FRAME) begin
            @(negedge clk);
            t++;
        end
        check("frame_wait", int'(frame_done), 1);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        load_valid = 1'b1; value_in = v; dp_in = d;
        cyc(1);
        load_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; value_in = '0; dp_in = '0; lz_blank_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // cycle 0 after release
        check("rst_en", int'(digit_en_n), 'hF);
        check("rst_dp", int'(dp_out_n), 1);
        check("rst_ready", int'(load_ready), 1);
        check("rst_nib", int'(nibble_out), 0);
        check("rst_fd", int'(frame_done), 0);
        cyc(1); check("blank1", int'(digit_en_n), 'hF);
        cyc(1); check("show0", int'(digit_en_n), 'hE);
        cyc(29); check("fd31", int'(frame_done), 1);
        check("fd31_en", int'(digit_en_n), 'h7);

        // load in the frame_done cycle: captured, commits a frame later
        load(16'h1234, 4'b0010);
        check("ld_busy", int'(load_ready), 0);
        wait_frame();
        check("old_nib", int'(nibble_out), 0);
        cyc(3);
        check("f2_nib0", int'(nibble_out), 4);
        check("f2_en0", int'(digit_en_n), 'hE);
        check("f2_dp0", int'(dp_out_n), 1);
        check("f2_ready", int'(load_ready), 1);
        cyc(8);
        check("f2_nib1", int'(nibble_out), 3);
        check("f2_en1", int'(digit_en_n), 'hD);
        check("f2_dp1", int'(dp_out_n), 0);

        // tear-free: load mid-frame, second offer dropped
        cyc(1);
        load(16'hABCD, 4'b0000);
        check("abcd_busy", int'(load_ready), 0);
        load_valid = 1'b1; value_in = 16'h5555;
        cyc(3);
        load_valid = 1'b0;
        wait_frame();
        check("abcd_old", int'(nibble_out), 1);
        cyc(1);
        check("abcd_new", int'(nibble_out), 'hD);
        check("abcd_ready", int'(load_ready), 1);

        // leading-zero blanking
        lz_blank_en = 1'b1;
        load(16'h0050, 4'b0000);
        wait_frame();
        cyc(3); check("lz_d0", int'(digit_en_n), 'hE);
        check("lz_n0", int'(nibble_out), 0);
        cyc(8); check("lz_d1", int'(digit_en_n), 'hD);
        check("lz_n1", int'(nibble_out), 5);
        cyc(8); check("lz_d2", int'(digit_en_n), 'hF);
        cyc(8); check("lz_d3", int'(digit_en_n), 'hF);
        load(16'h0000, 4'b0000);
        wait_frame();
        cyc(11); check("lz0_d1", int'(digit_en_n), 'hF);
        lz_blank_en = 1'b0;
        cyc(1); check("nolz_d1", int'(digit_en_n), 'hD);

        // boundary load of 9999
        wait_frame();
        load(16'h9999, 4'b0000);
        check("b_busy", int'(load_ready), 0);
        check("b_old", int'(nibble_out), 0);
        wait_frame();
        cyc(1); check("b_new", int'(nibble_out), 9);

        // reset during digit 2 SHOW with pending full
        load(16'h1234, 4'b1111);
        cyc(19);
        check("r_busy", int'(load_ready), 0);
        check("r_en2", int'(digit_en_n), 'hB);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("r_en", int'(digit_en_n), 'hF);
        check("r_ready", int'(load_ready), 1);
        check("r_nib", int'(nibble_out), 0);
        cyc(2); check("r_show0", int'(digit_en_n), 'hE);
        cyc(29); check("r_fd", int'(frame_done), 1);
        cyc(3); check("r_discard", int'(nibble_out), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            load_valid  = ($urandom_range(0, 9) < 3);
            value_in    = 16'($urandom);
            dp_in       = 4'($urandom);
            if ($urandom_range(0, 9) == 0) lz_blank_en = ~lz_blank_en;
            rst         = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0; load_valid = 1'b0;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
